// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: opcode classes,
// datapath width and the load funct3 width/sign codes.
package wb_stage_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JAL    = 3'd4,
        OP_JALR   = 3'd5,
        OP_CSR    = 3'd6,
        OP_SYS    = 3'd7
    } opc_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Load data extraction: shifts the aligned doubleword down by the byte
// offset and sign/zero-extends according to the load width code.
// Misaligned accesses are not detected; only the offset bits are used.
module load_extract
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Width select and extension of the shifted doubleword
    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   data = shifted;
            F3_LBU:  data = {{(XLEN-8){1'b0}},  shifted[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LWU:  data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the RV64 pipeline. Registers the MEM-stage result,
// selects the final writeback value and drives the register-file write
// port, the execute-stage forwarding tap and the retire interface.
// Optional feature macro: WB_INSTRET_EN enables the retired-instruction
// counter; without it instret is constant zero and no counter exists.
module wb_stage #(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  wb_stage_pkg::opc_e  in_op,
    input  logic [2:0]          in_funct3,
    input  logic [XLEN-1:0]     in_alu_result,
    input  logic [XLEN-1:0]     in_mem_rdata,
    input  logic [XLEN-1:0]     in_csr_rdata,
    input  logic [4:0]          in_rd,
    input  logic                in_reg_write,
    input  logic                stall,
    input  logic                flush,
    output logic                wb_en,
    output logic [4:0]          wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic                fwd_valid,
    output logic                commit_valid,
    output logic [XLEN-1:0]     commit_pc,
    output logic [63:0]         instret
);

    import wb_stage_pkg::*;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    opc_e            op_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] csr_q;
    logic [4:0]      rd_q;
    logic            reg_write_q;

    logic            retire;
    logic            writes_rd;
    logic [XLEN-1:0] load_data;

    // Stage register: load on !stall, flush squashes only the incoming op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            pc_q        <= RESET_PC[XLEN-1:0];
            op_q        <= OP_ALU;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            csr_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid && !flush;
            pc_q        <= in_pc;
            op_q        <= in_op;
            funct3_q    <= in_funct3;
            alu_q       <= in_alu_result;
            rdata_q     <= in_mem_rdata;
            csr_q       <= in_csr_rdata;
            rd_q        <= in_rd;
            reg_write_q <= in_reg_write;
        end
    end

    load_extract u_load_extract (
        .rdata  (rdata_q),
        .offset (alu_q[2:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Final result select from the registered fields
    always_comb begin
        wb_data = alu_q;
        case (op_q)
            OP_LOAD:         wb_data = load_data;
            OP_JAL, OP_JALR: wb_data = pc_q + XLEN'(4);
            OP_CSR:          wb_data = csr_q;
            default:         wb_data = alu_q;
        endcase
    end

    assign in_ready     = !stall;
    assign retire       = valid_q && !stall;
    // The forwarding tap ignores stall so execute can bypass a held result
    assign writes_rd    = valid_q && reg_write_q && (rd_q != 5'd0);
    assign fwd_valid    = writes_rd;
    assign wb_en        = writes_rd && !stall;
    assign wb_addr      = rd_q;
    assign commit_valid = retire;
    assign commit_pc    = pc_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV64 pipeline.
- Registers the MEM-stage result and extracts/extends load data from the aligned doubleword.
- Selects the final result: ALU, load, pc+4 or CSR old value.
- Drives the single register-file write port plus a forwarding tap back to the execute-stage operand selectors.

Parameters:
- XLEN, 64, datapath width (only 64 supported)
- RESET_PC, 64'h0, value of commit_pc after reset

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage accepts this cycle; equals !stall
- in_pc  in  64  instruction pc
- in_op  in  OPC  decoded opcode class (common package)
- in_funct3  in  3  load width/sign code
- in_alu_result  in  64  ALU result / load effective address
- in_mem_rdata  in  64  aligned doubleword from data memory
- in_csr_rdata  in  64  CSR old value
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- stall  in  1  hold stage contents
- flush  in  1  discard incoming instruction
- wb_en  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  64  register-file write data
- fwd_valid  out  1  wb_addr/wb_data hold a pending result for forwarding
- commit_valid  out  1  an instruction retires this cycle
- commit_pc  out  64  pc of retiring instruction
- instret  out  64  retired-instruction count

Behaviour:
- Reset (async, reset_n=0):
  - valid_q=0; all data registers 0; commit_pc=RESET_PC; instret=0.
  - All outputs 0 except commit_pc.
- Capture at posedge:
  - When !stall: valid_q <= in_valid && !flush; data fields load from in_*.
  - When stall: all registers hold.
  - flush squashes only the incoming instruction, never the held entry.
- Retire: retire = valid_q && !stall.
  - commit_valid = retire.
  - wb_en = retire && reg_write_q && (rd_q != 0).
  - Latency: capture at edge N, write visible in cycle N+1.
  - A stalled entry writes exactly once, in the first cycle stall is low.
- fwd_valid = valid_q && reg_write_q && rd_q != 0, independent of stall, so execute can bypass a held result.
- Result select (combinational from registered fields):
  - LOAD: extracted load data.
  - JAL/JALR: pc_q + 4 (wraps mod 2^64).
  - CSR: csr_rdata_q.
  - otherwise: alu_result_q.
- Load extraction: byte offset = alu_result_q[2:0]; shift rdata right by offset*8, then:
  - funct3 000 LB: sign-extend 8.
  - 001 LH: sign-extend 16.
  - 010 LW: sign-extend 32.
  - 011 LD: full 64.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: result 0.
  - Misalignment is not checked; the shift uses only the offset bits.
- wb_addr and wb_data are valid whenever valid_q=1; they are don't-care but stable when valid_q=0.
- Reset asserted mid-stall clears the held entry; no write occurs.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - instret is a 64-bit register incremented on every retire.
  - Wraps 2^64-1 -> 0.
- Undefined:
  - instret tied to 0; no counter flops.

Decomposition:
- OPC enum, XLEN and the funct3 load codes (LB..LWU) belong in the common package.
- Load extraction is a natural combinational sub-module: load_extract (inputs rdata, offset, funct3; output data).

Test Plan:
- Reset: hold reset_n=0, drive in_valid=1 -> wb_en=0, commit_valid=0, instret=0; after release, first accepted op writes in the next cycle.
- LB at offset 3, rdata=64'h0000_0000_80FF_0000 -> wb_data=64'hFFFF_FFFF_FFFF_FF80; same with LBU -> 64'h80; LW offset 4, rdata=64'h8000_0000_0000_0000 -> 64'hFFFF_FFFF_8000_0000.
- JAL pc=64'h8000_0000, rd=1 -> wb_data=64'h8000_0004, wb_en=1; same with rd=0 -> wb_en=0, commit_valid=1.
- Stall held 3 cycles over an ADD rd=5 -> fwd_valid=1 throughout, wb_en=0 during stall, exactly one wb_en pulse when stall drops, instret +1.
- flush with in_valid=1 -> no write/commit next cycle; flush while stalled -> held entry still retires after stall.
- WB_INSTRET_EN defined, 10 back-to-back retires -> instret=10; force counter to 2^64-1 and retire -> 0; undefined -> instret stays 0.
